// File: rtl/amo_pkg.sv
// Shared encodings for the TCDM atomic protocol: bank AMO codes, RISC-V funct5 values
// and the initiator FSM states.
package amo_pkg;

    typedef enum logic [3:0] {
        AMO_NONE = 4'h0,
        AMO_SWAP = 4'h1,
        AMO_ADD  = 4'h2,
        AMO_AND  = 4'h3,
        AMO_OR   = 4'h4,
        AMO_XOR  = 4'h5,
        AMO_MAX  = 4'h6,
        AMO_MAXU = 4'h7,
        AMO_MIN  = 4'h8,
        AMO_MINU = 4'h9,
        AMO_CAS  = 4'hA
    } amo_op_t;

    localparam logic [4:0] FUNCT5_ADD  = 5'b00000;
    localparam logic [4:0] FUNCT5_SWAP = 5'b00001;
    localparam logic [4:0] FUNCT5_XOR  = 5'b00100;
    localparam logic [4:0] FUNCT5_AND  = 5'b01100;
    localparam logic [4:0] FUNCT5_OR   = 5'b01000;
    localparam logic [4:0] FUNCT5_MIN  = 5'b10000;
    localparam logic [4:0] FUNCT5_MAX  = 5'b10100;
    localparam logic [4:0] FUNCT5_MINU = 5'b11000;
    localparam logic [4:0] FUNCT5_MAXU = 5'b11100;
    // Custom compare-and-swap; occupies a funct5 slot unused by the A extension.
    localparam logic [4:0] FUNCT5_CAS  = 5'b00101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_RSP
    } state_t;

endpackage

// File: rtl/amo_op_decoder.sv
// Maps a core funct5 to the bank AMO code and flags ops the bank cannot execute
// (LR/SC, unknown funct5, misaligned AMOs, CAS outside lane 0 or without 64-bit banks).
module amo_op_decoder
    import amo_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter bit EnableCas = 1'b1
) (
    input  logic [4:0] funct5,
    input  logic       is_amo,
    input  logic [2:0] addr,
    output logic [3:0] op,
    output logic       err
);

    always_comb begin
        op  = AMO_NONE;
        err = 1'b0;
        if (is_amo) begin
            case (funct5)
                FUNCT5_ADD:  op = AMO_ADD;
                FUNCT5_SWAP: op = AMO_SWAP;
                FUNCT5_XOR:  op = AMO_XOR;
                FUNCT5_AND:  op = AMO_AND;
                FUNCT5_OR:   op = AMO_OR;
                FUNCT5_MIN:  op = AMO_MIN;
                FUNCT5_MAX:  op = AMO_MAX;
                FUNCT5_MINU: op = AMO_MINU;
                FUNCT5_MAXU: op = AMO_MAXU;
                FUNCT5_CAS: begin
                    if (EnableCas && DataWidth == 64 && !addr[2]) op = AMO_CAS;
                    else err = 1'b1;
                end
                default: err = 1'b1;
            endcase
            if (addr[1:0] != 2'b00) err = 1'b1;
            if (err) op = AMO_NONE;
        end
    end

endmodule

// File: rtl/amo_req_initiator.sv
// Core-side TCDM initiator: one outstanding load/store/AMO, lane-packs the request for a
// 32/64-bit bank and returns the lane-extracted old word to the core.
module amo_req_initiator
    import amo_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter bit EnableCas = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   core_req_valid_i,
    output logic                   core_req_ready_o,
    input  logic [AddrWidth-1:0]   core_addr_i,
    input  logic                   core_we_i,
    input  logic                   core_is_amo_i,
    input  logic [4:0]             core_funct5_i,
    input  logic [31:0]            core_wdata_i,
    input  logic [31:0]            core_cas_new_i,
    input  logic [3:0]             core_be_i,
    output logic                   core_rsp_valid_o,
    input  logic                   core_rsp_ready_i,
    output logic [31:0]            core_rsp_data_o,
    output logic                   core_rsp_err_o,
    output logic                   tcdm_req_o,
    input  logic                   tcdm_gnt_i,
    output logic [AddrWidth-1:0]   tcdm_add_o,
    output logic [3:0]             tcdm_amo_o,
    output logic                   tcdm_wen_o,
    output logic [DataWidth-1:0]   tcdm_wdata_o,
    output logic [DataWidth/8-1:0] tcdm_be_o,
    input  logic                   tcdm_rvalid_i,
    input  logic [DataWidth-1:0]   tcdm_rdata_i
);

    localparam int BeWidth  = DataWidth / 8;
    localparam int NumLanes = DataWidth / 32;

    if (DataWidth != 32 && DataWidth != 64) begin : g_dw_check
        $fatal(1, "amo_req_initiator: DataWidth must be 32 or 64");
    end

    state_t state, state_d;

    logic [AddrWidth-1:0] addr_q;
    logic [3:0]           amo_q;
    logic                 wen_q;
    logic [DataWidth-1:0] wdata_q;
    logic [BeWidth-1:0]   be_q;
    logic                 lane_q;
    logic [31:0]          rdata_q;
    logic                 err_q;

    logic [3:0]           dec_op;
    logic                 dec_err;
    logic                 lane_in;
    logic                 accept;
    logic [63:0]          cas_data;
    logic [DataWidth-1:0] wdata_pack;
    logic [BeWidth-1:0]   be_pack;
    logic [DataWidth-1:0] rdata_sh;

    amo_op_decoder #(
        .DataWidth (DataWidth),
        .EnableCas (EnableCas)
    ) u_dec (
        .funct5 (core_funct5_i),
        .is_amo (core_is_amo_i),
        .addr   (core_addr_i[2:0]),
        .op     (dec_op),
        .err    (dec_err)
    );

    assign lane_in  = (DataWidth == 64) ? core_addr_i[2] : 1'b0;
    assign accept   = core_req_valid_i && core_req_ready_o;
    assign cas_data = {core_cas_new_i, core_wdata_i};

    always_comb begin
        wdata_pack = {NumLanes{core_wdata_i}};
        be_pack    = '0;
        if (dec_op == AMO_CAS) begin
            wdata_pack   = cas_data[DataWidth-1:0];
            be_pack[3:0] = 4'hF;
        end else if (core_is_amo_i) begin
            be_pack = BeWidth'(4'hF) << {lane_in, 2'b00};
        end else begin
            be_pack = BeWidth'(core_be_i) << {lane_in, 2'b00};
        end
    end

    // Shift the addressed 32-bit lane down to bit 0; works for both bank widths.
    assign rdata_sh = tcdm_rdata_i >> {lane_q, 5'b00000};

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:     if (accept) state_d = dec_err ? ST_RSP : ST_REQ;
            ST_REQ:      if (tcdm_gnt_i) state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: if (tcdm_rvalid_i) state_d = ST_RSP;
            ST_RSP:      if (core_rsp_ready_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            amo_q   <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            lane_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && accept) begin
                addr_q  <= core_addr_i;
                amo_q   <= dec_op;
                wen_q   <= core_is_amo_i ? 1'b0 : core_we_i;
                wdata_q <= wdata_pack;
                be_q    <= be_pack;
                lane_q  <= lane_in;
                rdata_q <= '0;
                err_q   <= dec_err;
            end else if (state == ST_WAIT_RSP && tcdm_rvalid_i) begin
                rdata_q <= rdata_sh[31:0];
            end
        end
    end

    // Ready is masked during reset so every output reads 0 while rst_ni is low.
    assign core_req_ready_o = (state == ST_IDLE) && rst_ni;
    assign core_rsp_valid_o = (state == ST_RSP);
    assign core_rsp_data_o  = rdata_q;
    assign core_rsp_err_o   = (state == ST_RSP) && err_q;

    assign tcdm_req_o   = (state == ST_REQ);
    assign tcdm_add_o   = addr_q;
    assign tcdm_amo_o   = amo_q;
    assign tcdm_wen_o   = wen_q;
    assign tcdm_wdata_o = wdata_q;
    assign tcdm_be_o    = be_q;

endmodule

// File: tb/tb_amo_req_initiator.sv
// Directed bench: vector table of single transactions on a 64-bit bank, hand sequences for
// stalls, backpressure and reset, plus a 32-bit bank instance.
module tb_amo_req_initiator;
    import amo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // 64-bit bank instance
    logic        req_valid, req_ready, we, is_amo, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] addr, wdata, cas_new, rsp_data, tcdm_add;
    logic [4:0]  funct5;
    logic [3:0]  be, tcdm_amo;
    logic        tcdm_req, tcdm_gnt, tcdm_wen, tcdm_rvalid;
    logic [63:0] tcdm_wdata, tcdm_rdata;
    logic [7:0]  tcdm_be;

    amo_req_initiator #(.AddrWidth(32), .DataWidth(64), .EnableCas(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_valid_i(req_valid), .core_req_ready_o(req_ready),
        .core_addr_i(addr), .core_we_i(we), .core_is_amo_i(is_amo),
        .core_funct5_i(funct5), .core_wdata_i(wdata), .core_cas_new_i(cas_new),
        .core_be_i(be), .core_rsp_valid_o(rsp_valid), .core_rsp_ready_i(rsp_ready),
        .core_rsp_data_o(rsp_data), .core_rsp_err_o(rsp_err),
        .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add),
        .tcdm_amo_o(tcdm_amo), .tcdm_wen_o(tcdm_wen), .tcdm_wdata_o(tcdm_wdata),
        .tcdm_be_o(tcdm_be), .tcdm_rvalid_i(tcdm_rvalid), .tcdm_rdata_i(tcdm_rdata)
    );

    // 32-bit bank instance
    logic        s_req_valid, s_req_ready, s_we, s_is_amo, s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [31:0] s_addr, s_wdata, s_cas_new, s_rsp_data, s_tcdm_add, s_tcdm_wdata, s_tcdm_rdata;
    logic [4:0]  s_funct5;
    logic [3:0]  s_be, s_tcdm_amo, s_tcdm_be;
    logic        s_tcdm_req, s_tcdm_gnt, s_tcdm_wen, s_tcdm_rvalid;

    amo_req_initiator #(.AddrWidth(32), .DataWidth(32), .EnableCas(1'b1)) dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_valid_i(s_req_valid), .core_req_ready_o(s_req_ready),
        .core_addr_i(s_addr), .core_we_i(s_we), .core_is_amo_i(s_is_amo),
        .core_funct5_i(s_funct5), .core_wdata_i(s_wdata), .core_cas_new_i(s_cas_new),
        .core_be_i(s_be), .core_rsp_valid_o(s_rsp_valid), .core_rsp_ready_i(s_rsp_ready),
        .core_rsp_data_o(s_rsp_data), .core_rsp_err_o(s_rsp_err),
        .tcdm_req_o(s_tcdm_req), .tcdm_gnt_i(s_tcdm_gnt), .tcdm_add_o(s_tcdm_add),
        .tcdm_amo_o(s_tcdm_amo), .tcdm_wen_o(s_tcdm_wen), .tcdm_wdata_o(s_tcdm_wdata),
        .tcdm_be_o(s_tcdm_be), .tcdm_rvalid_i(s_tcdm_rvalid), .tcdm_rdata_i(s_tcdm_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic        am;
        logic [4:0]  f5;
        logic [31:0] wd;
        logic [31:0] cn;
        logic [3:0]  b;
        logic [63:0] rd;
        logic        x_err;
        logic [3:0]  x_amo;
        logic        x_wen;
        logic [7:0]  x_be;
        logic [63:0] x_wd;
        logic [31:0] x_rsp;
    } vec_t;

    function automatic vec_t mk(logic [31:0] a, logic w, logic am, logic [4:0] f5,
                                logic [31:0] wd, logic [31:0] cn, logic [3:0] b,
                                logic [63:0] rd, logic x_err, logic [3:0] x_amo,
                                logic x_wen, logic [7:0] x_be, logic [63:0] x_wd,
                                logic [31:0] x_rsp);
        vec_t v;
        v.a = a; v.w = w; v.am = am; v.f5 = f5; v.wd = wd; v.cn = cn; v.b = b; v.rd = rd;
        v.x_err = x_err; v.x_amo = x_amo; v.x_wen = x_wen; v.x_be = x_be;
        v.x_wd = x_wd; v.x_rsp = x_rsp;
        return v;
    endfunction

    // Wait (bounded) for ready, then present the request for exactly one accepting edge.
    task automatic accept(input vec_t v);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_before_req", req_ready, 1'b1);
        addr = v.a; we = v.w; is_amo = v.am; funct5 = v.f5;
        wdata = v.wd; cas_new = v.cn; be = v.b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check_req(input vec_t v, input string tag);
        chk({tag, "_req"},   tcdm_req, 1'b1);
        chk({tag, "_add"},   tcdm_add, v.a);
        chk({tag, "_amo"},   tcdm_amo, v.x_amo);
        chk({tag, "_wen"},   tcdm_wen, v.x_wen);
        chk({tag, "_be"},    tcdm_be, v.x_be);
        chk({tag, "_wdata"}, tcdm_wdata, v.x_wd);
        chk({tag, "_ready"}, req_ready, 1'b0);
    endtask

    task automatic grant_and_return(input logic [63:0] rd);
        tcdm_gnt = 1'b1;
        tick();
        tcdm_gnt = 1'b0;
        chk("req_dropped_after_gnt", tcdm_req, 1'b0);
        tcdm_rvalid = 1'b1; tcdm_rdata = rd;
        tick();
        tcdm_rvalid = 1'b0; tcdm_rdata = '0;
    endtask

    task automatic check_rsp(input logic [31:0] d, input logic e, input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, "_rsp_data"},  rsp_data, d);
        chk({tag, "_rsp_err"},   rsp_err, e);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_cleared", rsp_valid, 1'b0);
        chk("ready_back_in_idle", req_ready, 1'b1);
    endtask

    vec_t vecs[16];

    initial begin
        vec_t v;
        rst_n = 1'b0;
        req_valid = 0; addr = 0; we = 0; is_amo = 0; funct5 = 0; wdata = 0; cas_new = 0; be = 0;
        rsp_ready = 0; tcdm_gnt = 0; tcdm_rvalid = 0; tcdm_rdata = 0;
        s_req_valid = 0; s_addr = 0; s_we = 0; s_is_amo = 0; s_funct5 = 0; s_wdata = 0;
        s_cas_new = 0; s_be = 0; s_rsp_ready = 0; s_tcdm_gnt = 0; s_tcdm_rvalid = 0;
        s_tcdm_rdata = 0;

        //          addr   we am f5     wdata        cas_new be  rdata                  err amo  wen be     wdata_exp              rsp
        vecs[0]  = mk(32'h104, 0, 1, 5'b00000, 32'h5, 0, 4'h0, 64'h00000007_00000000, 0, 4'h2, 0, 8'hF0, 64'h00000005_00000005, 32'h7);
        vecs[1]  = mk(32'h100, 0, 1, 5'b00101, 32'h3, 32'h9, 4'h0, 64'hDEAD0000_12345678, 0, 4'hA, 0, 8'h0F, 64'h00000009_00000003, 32'h12345678);
        vecs[2]  = mk(32'h104, 0, 1, 5'b00101, 32'h3, 32'h9, 4'h0, 64'h0, 1, 4'h0, 0, 8'h00, 64'h0, 32'h0);
        vecs[3]  = mk(32'h100, 0, 1, 5'b00010, 32'h1, 0, 4'h0, 64'h0, 1, 4'h0, 0, 8'h00, 64'h0, 32'h0);
        vecs[4]  = mk(32'h102, 0, 1, 5'b00000, 32'h1, 0, 4'h0, 64'h0, 1, 4'h0, 0, 8'h00, 64'h0, 32'h0);
        vecs[5]  = mk(32'h208, 1, 0, 5'b00000, 32'hAABBCCDD, 0, 4'h3, 64'h11111111_22222222, 0, 4'h0, 1, 8'h03, 64'hAABBCCDD_AABBCCDD, 32'h22222222);
        vecs[6]  = mk(32'h20C, 0, 0, 5'b00000, 32'h0, 0, 4'hF, 64'h89ABCDEF_01234567, 0, 4'h0, 0, 8'hF0, 64'h0, 32'h89ABCDEF);
        vecs[7]  = mk(32'h300, 1, 1, 5'b00001, 32'h1, 0, 4'h0, 64'h00000000_00000042, 0, 4'h1, 0, 8'h0F, 64'h00000001_00000001, 32'h42);
        vecs[8]  = mk(32'h304, 0, 1, 5'b11100, 32'hFFFFFFFF, 0, 4'h0, 64'h80000000_00000001, 0, 4'h7, 0, 8'hF0, 64'hFFFFFFFF_FFFFFFFF, 32'h80000000);
        vecs[9]  = mk(32'h308, 0, 1, 5'b10000, 32'h2, 0, 4'h0, 64'h00000005_00000003, 0, 4'h8, 0, 8'h0F, 64'h00000002_00000002, 32'h3);
        vecs[10] = mk(32'h30C, 0, 1, 5'b01100, 32'hF0F0, 0, 4'h0, 64'h00001234_00000000, 0, 4'h3, 0, 8'hF0, 64'h0000F0F0_0000F0F0, 32'h1234);
        vecs[11] = mk(32'h310, 0, 1, 5'b01000, 32'h8, 0, 4'h0, 64'h0, 0, 4'h4, 0, 8'h0F, 64'h00000008_00000008, 32'h0);
        vecs[12] = mk(32'h314, 0, 1, 5'b10100, 32'h9, 0, 4'h0, 64'h00000011_00000022, 0, 4'h6, 0, 8'hF0, 64'h00000009_00000009, 32'h11);
        vecs[13] = mk(32'h318, 0, 1, 5'b11000, 32'hA, 0, 4'h0, 64'h00000011_00000022, 0, 4'h9, 0, 8'h0F, 64'h0000000A_0000000A, 32'h22);
        vecs[14] = mk(32'h100, 0, 1, 5'b00011, 32'h1, 0, 4'h0, 64'h0, 1, 4'h0, 0, 8'h00, 64'h0, 32'h0);
        vecs[15] = mk(32'h004, 1, 0, 5'b00000, 32'h0000BEEF, 0, 4'hC, 64'h0, 0, 4'h0, 1, 8'hC0, 64'h0000BEEF_0000BEEF, 32'h0);

        // Reset state
        tick(); tick();
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_req", tcdm_req, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_outputs", {tcdm_add, tcdm_amo, tcdm_wen, tcdm_be, rsp_err}, '0);
        chk("rst_wdata", tcdm_wdata, '0);
        chk("rst_rsp_data", rsp_data, '0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 1'b1);

        foreach (vecs[i]) begin
            v = vecs[i];
            accept(v);
            if (v.x_err) begin
                chk($sformatf("v%0d_no_req", i), tcdm_req, 1'b0);
                check_rsp(32'h0, 1'b1, $sformatf("v%0d", i));
            end else begin
                check_req(v, $sformatf("v%0d", i));
                grant_and_return(v.rd);
                check_rsp(v.x_rsp, 1'b0, $sformatf("v%0d", i));
            end
            release_rsp();
        end

        // Grant withheld 5 cycles while the core scribbles over its inputs
        v = mk(32'h400, 0, 1, 5'b00100, 32'h55, 0, 4'h0, 64'h0, 0, 4'h5, 0, 8'h0F, 64'h00000055_00000055, 32'h0);
        accept(v);
        addr = 32'h804; wdata = 32'hFFFF; funct5 = 5'b00000; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_req(v, $sformatf("stall%0d", c));
            tick();
        end
        req_valid = 1'b0;
        check_req(v, "stall_end");
        grant_and_return(64'hAAAAAAAA_00000066);
        check_rsp(32'h66, 1'b0, "stall");

        // Core backpressure on the response, with a new request pending
        addr = 32'h500; is_amo = 1'b0; we = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_rsp(32'h66, 1'b0, $sformatf("bp%0d", c));
            chk($sformatf("bp%0d_ready", c), req_ready, 1'b0);
            chk($sformatf("bp%0d_req", c), tcdm_req, 1'b0);
            tick();
        end
        req_valid = 1'b0;
        release_rsp();

        // Reset while waiting for rvalid; the late rvalid must be ignored
        v = mk(32'h600, 0, 1, 5'b00000, 32'h1, 0, 4'h0, 64'h0, 0, 4'h2, 0, 8'h0F, 64'h00000001_00000001, 32'h0);
        accept(v);
        check_req(v, "mrst");
        tcdm_gnt = 1'b1;
        tick();
        tcdm_gnt = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mrst_req", tcdm_req, 1'b0);
        chk("mrst_ready", req_ready, 1'b0);
        chk("mrst_rsp_valid", rsp_valid, 1'b0);
        chk("mrst_outputs", {tcdm_add, tcdm_amo, tcdm_wen, tcdm_be, rsp_err, rsp_data}, '0);
        chk("mrst_wdata", tcdm_wdata, '0);
        rst_n = 1'b1;
        tcdm_rvalid = 1'b1; tcdm_rdata = 64'h12345678_9ABCDEF0;
        tick();
        tcdm_rvalid = 1'b0; tcdm_rdata = '0;
        chk("mrst_late_rvalid_rsp", rsp_valid, 1'b0);
        chk("mrst_late_rvalid_data", rsp_data, 32'h0);
        chk("mrst_idle_ready", req_ready, 1'b1);

        // 32-bit bank: plain store with partial strobes
        s_addr = 32'h10; s_we = 1'b1; s_be = 4'h3; s_wdata = 32'h12345678; s_req_valid = 1'b1;
        tick();
        s_req_valid = 1'b0;
        chk("dw32_req", s_tcdm_req, 1'b1);
        chk("dw32_be", s_tcdm_be, 4'h3);
        chk("dw32_wdata", s_tcdm_wdata, 32'h12345678);
        chk("dw32_wen", s_tcdm_wen, 1'b1);
        chk("dw32_amo", s_tcdm_amo, 4'h0);
        s_tcdm_gnt = 1'b1;
        tick();
        s_tcdm_gnt = 1'b0; s_tcdm_rvalid = 1'b1; s_tcdm_rdata = 32'hCAFEBABE;
        tick();
        s_tcdm_rvalid = 1'b0;
        chk("dw32_rsp_valid", s_rsp_valid, 1'b1);
        chk("dw32_rsp_data", s_rsp_data, 32'hCAFEBABE);
        s_rsp_ready = 1'b1;
        tick();
        s_rsp_ready = 1'b0;

        // 32-bit bank cannot do CAS
        s_addr = 32'h20; s_we = 1'b0; s_is_amo = 1'b1; s_funct5 = 5'b00101; s_req_valid = 1'b1;
        tick();
        s_req_valid = 1'b0;
        chk("dw32_cas_no_req", s_tcdm_req, 1'b0);
        chk("dw32_cas_err", s_rsp_err, 1'b1);
        chk("dw32_cas_data", s_rsp_data, 32'h0);
        s_rsp_ready = 1'b1;
        tick();
        s_rsp_ready = 1'b0;
        chk("dw32_idle", s_req_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
